// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte sources, each with a 1-deep holding register.
// Build option: define UART_TX_ARB_FIXED_PRIO_EN for fixed lowest-index priority (default is round-robin).
module uart_tx_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic                 clr_ovf,
   input  logic                 tx_done,
   output logic                 trmt,
   output logic [7:0]           resp,
   output logic [NUM_REQ-1:0]   ack,
   output logic [NUM_REQ-1:0]   pend,
   output logic [NUM_REQ-1:0]   ovf,
   output logic                 busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      XMIT = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [7:0]          hold [NUM_REQ];
   logic [IW-1:0]       grant;
   logic [IW-1:0]       grant_nxt;
   logic [IW-1:0]       sel_idx;
   logic                sel_found;
   logic                launch;
   logic                complete;
   logic                trmt_nxt;
   logic [7:0]          resp_nxt;
   logic [NUM_REQ-1:0]  ack_nxt;
   logic [NUM_REQ-1:0]  pend_nxt;
   logic [NUM_REQ-1:0]  ovf_nxt;
   logic [NUM_REQ-1:0]  load;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
   // Scanning downward lets the lowest pending index overwrite any higher one.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (pend[k]) begin
            sel_found = 1'b1;
            sel_idx   = IW'(k);
         end
      end
   end
`else
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] rr_ptr_nxt;

   function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end
      return IW'(sum);
   endfunction

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!sel_found && pend[wrap_idx(rr_ptr, k)]) begin
            sel_found = 1'b1;
            sel_idx   = wrap_idx(rr_ptr, k);
         end
      end
   end

   // The pointer only moves when a byte finishes, to the slot just past the winner.
   always_comb begin
      rr_ptr_nxt = complete ? wrap_idx(grant, 1) : rr_ptr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else begin
         rr_ptr <= rr_ptr_nxt;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sel_found) state_nxt = CLR;
         CLR:     if (!tx_done)  state_nxt = XMIT;
         XMIT:    if (tx_done)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A post landing on its own completion edge refills the slot instead of overflowing.
   always_comb begin
      launch    = (state == IDLE) && sel_found;
      complete  = (state == XMIT) && tx_done;
      trmt_nxt  = launch;
      resp_nxt  = launch ? hold[sel_idx] : resp;
      grant_nxt = launch ? sel_idx : grant;
      ack_nxt   = '0;
      if (complete) begin
         ack_nxt[grant] = 1'b1;
      end
      load     = req & (~pend | ack_nxt);
      pend_nxt = req | (pend & ~ack_nxt);
      ovf_nxt  = (ovf & ~{NUM_REQ{clr_ovf}}) | (req & pend & ~ack_nxt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trmt  <= 1'b0;
         resp  <= 8'h00;
         ack   <= '0;
         pend  <= '0;
         ovf   <= '0;
         grant <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            hold[i] <= 8'h00;
         end
      end else begin
         trmt  <= trmt_nxt;
         resp  <= resp_nxt;
         ack   <= ack_nxt;
         pend  <= pend_nxt;
         ovf   <= ovf_nxt;
         grant <= grant_nxt;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (load[i]) begin
               hold[i] <= req_data[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized batches checked
// against a transaction-level model of the grant order, overflow flags and back-to-back timing.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] req_data = '0;
   logic           clr_ovf = 1'b0;
   logic           tx_done;
   logic           trmt;
   logic [7:0]     resp;
   logic [N-1:0]   ack;
   logic [N-1:0]   pend;
   logic [N-1:0]   ovf;
   logic           busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int m_rr    = 0;
   int exp_src[$];

   bit   uart_en = 1'b1;
   logic uart_tx;
   logic man_tx = 1'b1;
   bit   uart_active;
   int   drop_dly = 1;
   int   xfer_len = 3;

   logic [7:0]   trmt_bytes[$];
   int           trmt_cyc[$];
   logic [N-1:0] ack_vecs[$];
   int           ack_cyc[$];
   int           glitch_cnt = 0;
   bit           in_flight = 1'b0;
   logic [7:0]   flight_resp = 8'h00;

   assign tx_done = uart_en ? uart_tx : man_tx;

   uart_tx_arbiter #(.NUM_REQ(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .clr_ovf  (clr_ovf),
      .tx_done  (tx_done),
      .trmt     (trmt),
      .resp     (resp),
      .ack      (ack),
      .pend     (pend),
      .ovf      (ovf),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Log every transmit strobe and ack; also note any resp change while a byte is in flight.
   always @(negedge clk) begin
      if (!rst_n) begin
         in_flight = 1'b0;
      end else begin
         if (in_flight && resp !== flight_resp) glitch_cnt++;
         if (trmt === 1'b1) begin
            trmt_bytes.push_back(resp);
            trmt_cyc.push_back(cyc);
            in_flight   = 1'b1;
            flight_resp = resp;
         end
         if (ack !== '0) begin
            ack_vecs.push_back(ack);
            ack_cyc.push_back(cyc);
            in_flight = 1'b0;
         end
      end
   end

   // UART wrapper model: after a strobe, tx_done drops after drop_dly cycles and rises xfer_len later.
   initial begin
      uart_tx     = 1'b1;
      uart_active = 1'b0;
      forever begin
         @(posedge clk); #2;
         if (uart_en && trmt === 1'b1) begin
            uart_active = 1'b1;
            repeat (drop_dly) begin @(posedge clk); #2; end
            uart_tx = 1'b0;
            repeat (xfer_len) begin @(posedge clk); #2; end
            uart_tx     = 1'b1;
            uart_active = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic post(input logic [N-1:0] mask, input logic [8*N-1:0] data);
      req      = mask;
      req_data = data;
      step();
      req = '0;
   endtask

   task automatic wait_quiet(input int max_cyc, output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < max_cyc) begin
         if (busy === 1'b0 && pend === '0 && !uart_active && trmt === 1'b0 && ack === '0) ok = 1'b1;
         else begin
            step();
            n++;
         end
      end
   endtask

   // Reference order for a batch posted in one cycle: rotation from the pointer, or ascending index.
   task automatic model_order(input logic [N-1:0] mask);
      exp_src.delete();
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      for (int k = 0; k < N; k++) if (mask[k]) exp_src.push_back(k);
`else
      for (int k = 0; k < N; k++) if (mask[(m_rr + k) % N]) exp_src.push_back((m_rr + k) % N);
      if (exp_src.size() > 0) m_rr = (exp_src[exp_src.size()-1] + 1) % N;
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({trmt, resp, ack, pend, ovf, busy} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got trmt=%b resp=%h ack=%b pend=%b ovf=%b busy=%b, want all zero",
                  trmt, resp, ack, pend, ovf, busy);
      end
      rst_n = 1'b1;
      step();
      step();
      n_tests++;
      if ({trmt, resp, ack, pend, ovf, busy} !== '0) begin
         n_fail++;
         $display("[TB] FAIL post_reset_idle: got trmt=%b resp=%h ack=%b pend=%b ovf=%b busy=%b, want all zero",
                  trmt, resp, ack, pend, ovf, busy);
      end
      m_rr = 0;
   endtask

   task automatic test_single();
      bit got;
      int n;
      bit ok;
      drop_dly = 1;
      xfer_len = 3;
      model_order(4'b0001);
      post(4'b0001, {24'h0, 8'hA5});
      n_tests++;
      if (pend !== 4'b0001 || trmt !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL single_pend_c1: got pend=%b trmt=%b, want pend=0001 trmt=0", pend, trmt);
      end
      step();
      n_tests++;
      if (trmt !== 1'b1 || resp !== 8'hA5 || busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL single_trmt_c2: got trmt=%b resp=%h busy=%b, want trmt=1 resp=a5 busy=1", trmt, resp, busy);
      end
      step();
      n_tests++;
      if (trmt !== 1'b0 || resp !== 8'hA5) begin
         n_fail++;
         $display("[TB] FAIL single_trmt_pulse: got trmt=%b resp=%h, want trmt=0 resp=a5", trmt, resp);
      end
      got = 1'b0;
      n   = 0;
      while (!got && n < 50) begin
         if (ack !== '0) got = 1'b1;
         else begin
            step();
            n++;
         end
      end
      n_tests++;
      if (!got || ack !== 4'b0001 || pend !== '0 || resp !== 8'hA5) begin
         n_fail++;
         $display("[TB] FAIL single_ack: got seen=%0b ack=%b pend=%b resp=%h, want ack=0001 pend=0000 resp=a5",
                  got, ack, pend, resp);
      end
      step();
      n_tests++;
      if (ack !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL single_ack_pulse: got ack=%b busy=%b, want ack=0000 busy=0", ack, busy);
      end
      wait_quiet(50, ok);
   endtask

   task automatic test_rotation();
      int tb0, ab0;
      bit ok;
      logic [8*N-1:0] data;
      drop_dly = 0;
      xfer_len = 2;
      tb0 = trmt_bytes.size();
      ab0 = ack_vecs.size();
      model_order(4'b0010);
      post(4'b0010, {16'h0, 8'h22, 8'h00});
      wait_quiet(100, ok);
      n_tests++;
      if (!ok || trmt_bytes.size() != tb0 + 1 || ack_vecs.size() != ab0 + 1) begin
         n_fail++;
         $display("[TB] FAIL rot_first_count: got quiet=%0b bytes=%0d acks=%0d, want quiet=1 bytes=1 acks=1",
                  ok, trmt_bytes.size() - tb0, ack_vecs.size() - ab0);
      end else if (trmt_bytes[tb0] !== 8'h22 || ack_vecs[ab0] !== 4'b0010) begin
         n_fail++;
         $display("[TB] FAIL rot_first: got byte=%h ack=%b, want byte=22 ack=0010", trmt_bytes[tb0], ack_vecs[ab0]);
      end
      tb0  = trmt_bytes.size();
      ab0  = ack_vecs.size();
      data = {16'h0, 8'h33, 8'h11};
      model_order(4'b0011);
      post(4'b0011, data);
      wait_quiet(100, ok);
      n_tests++;
      if (!ok || trmt_bytes.size() != tb0 + 2 || ack_vecs.size() != ab0 + 2) begin
         n_fail++;
         $display("[TB] FAIL rot_pair_count: got quiet=%0b bytes=%0d acks=%0d, want quiet=1 bytes=2 acks=2",
                  ok, trmt_bytes.size() - tb0, ack_vecs.size() - ab0);
      end else begin
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (trmt_bytes[tb0+k] !== data[8*exp_src[k] +: 8] || ack_vecs[ab0+k] !== N'(1 << exp_src[k])) begin
               n_fail++;
               $display("[TB] FAIL rot_order[%0d]: got byte=%h ack=%b, want byte=%h ack=%b", k,
                        trmt_bytes[tb0+k], ack_vecs[ab0+k], data[8*exp_src[k] +: 8], N'(1 << exp_src[k]));
            end
         end
         n_tests++;
         if (trmt_cyc[tb0+1] != ack_cyc[ab0] + 1) begin
            n_fail++;
            $display("[TB] FAIL rot_back_to_back: got second trmt cycle=%0d, want %0d",
                     trmt_cyc[tb0+1], ack_cyc[ab0] + 1);
         end
      end
   endtask

   task automatic test_priority();
      int tb0;
      bit ok;
      logic [8*N-1:0] data;
      drop_dly = 1;
      xfer_len = 2;
      model_order(4'b0001);
      post(4'b0001, {24'h0, 8'h40});
      wait_quiet(100, ok);
      tb0  = trmt_bytes.size();
      data = {16'h0, 8'h42, 8'h41};
      model_order(4'b0011);
      post(4'b0011, data);
      wait_quiet(100, ok);
      n_tests++;
      if (!ok || trmt_bytes.size() != tb0 + 2) begin
         n_fail++;
         $display("[TB] FAIL prio_count: got quiet=%0b bytes=%0d, want quiet=1 bytes=2", ok, trmt_bytes.size() - tb0);
      end else begin
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (trmt_bytes[tb0+k] !== data[8*exp_src[k] +: 8]) begin
               n_fail++;
               $display("[TB] FAIL prio_order[%0d]: got byte=%h, want byte=%h", k,
                        trmt_bytes[tb0+k], data[8*exp_src[k] +: 8]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      int tb0;
      bit ok;
      drop_dly = 0;
      xfer_len = 8;
      tb0 = trmt_bytes.size();
      model_order(4'b0001);
      post(4'b0001, {24'h0, 8'h55});
      post(4'b0001, {24'h0, 8'h66});
      n_tests++;
      if (ovf !== 4'b0001 || pend[0] !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL ovf_set: got ovf=%b pend=%b, want ovf=0001 pend[0]=1", ovf, pend);
      end
      step();
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      n_tests++;
      if (ovf !== '0) begin
         n_fail++;
         $display("[TB] FAIL ovf_clear: got ovf=%b, want 0000", ovf);
      end
      wait_quiet(100, ok);
      n_tests++;
      if (!ok || trmt_bytes.size() != tb0 + 1) begin
         n_fail++;
         $display("[TB] FAIL ovf_dropped_count: got quiet=%0b bytes=%0d, want quiet=1 bytes=1", ok, trmt_bytes.size() - tb0);
      end else if (trmt_bytes[tb0] !== 8'h55) begin
         n_fail++;
         $display("[TB] FAIL ovf_kept_byte: got byte=%h, want 55", trmt_bytes[tb0]);
      end
      tb0 = trmt_bytes.size();
      model_order(4'b0001);
      post(4'b0001, {24'h0, 8'h5A});
      clr_ovf = 1'b1;
      post(4'b0001, {24'h0, 8'h5B});
      clr_ovf = 1'b0;
      n_tests++;
      if (ovf !== 4'b0001) begin
         n_fail++;
         $display("[TB] FAIL ovf_set_wins: got ovf=%b, want 0001", ovf);
      end
      wait_quiet(100, ok);
      n_tests++;
      if (!ok || trmt_bytes.size() != tb0 + 1 || trmt_bytes[tb0] !== 8'h5A) begin
         n_fail++;
         $display("[TB] FAIL ovf_second_byte: got quiet=%0b bytes=%0d, want quiet=1 one byte 5a",
                  ok, trmt_bytes.size() - tb0);
      end
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
   endtask

   task automatic test_post_on_completion();
      bit ok;
      man_tx  = 1'b1;
      uart_en = 1'b0;
      model_order(4'b0001);
      post(4'b0001, {24'h0, 8'h70});
      step();
      n_tests++;
      if (trmt !== 1'b1 || resp !== 8'h70) begin
         n_fail++;
         $display("[TB] FAIL poc_first_trmt: got trmt=%b resp=%h, want trmt=1 resp=70", trmt, resp);
      end
      man_tx = 1'b0;
      step();
      step();
      man_tx   = 1'b1;
      req      = 4'b0001;
      req_data = {24'h0, 8'h77};
      step();
      req = '0;
      n_tests++;
      if (ack !== 4'b0001 || pend !== 4'b0001 || ovf !== '0) begin
         n_fail++;
         $display("[TB] FAIL poc_ack_edge: got ack=%b pend=%b ovf=%b, want ack=0001 pend=0001 ovf=0000", ack, pend, ovf);
      end
      model_order(4'b0001);
      step();
      n_tests++;
      if (trmt !== 1'b1 || resp !== 8'h77) begin
         n_fail++;
         $display("[TB] FAIL poc_refill_sent: got trmt=%b resp=%h, want trmt=1 resp=77", trmt, resp);
      end
      man_tx = 1'b0;
      step();
      step();
      man_tx = 1'b1;
      step();
      n_tests++;
      if (ack !== 4'b0001 || pend !== '0) begin
         n_fail++;
         $display("[TB] FAIL poc_second_ack: got ack=%b pend=%b, want ack=0001 pend=0000", ack, pend);
      end
      uart_en = 1'b1;
      wait_quiet(50, ok);
   endtask

   task automatic test_reset_mid();
      int tb0, ab0;
      bit ok;
      drop_dly = 0;
      xfer_len = 20;
      ab0 = ack_vecs.size();
      post(4'b0100, {8'h0, 8'h99, 16'h0});
      step();
      step();
      step();
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (trmt !== 1'b0 || pend !== '0 || busy !== 1'b0 || ack !== '0 || resp !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL rstmid_outputs: got trmt=%b pend=%b busy=%b ack=%b resp=%h, want all zero",
                  trmt, pend, busy, ack, resp);
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_rr  = 0;
      wait_quiet(100, ok);
      n_tests++;
      if (!ok || ack_vecs.size() != ab0) begin
         n_fail++;
         $display("[TB] FAIL rstmid_no_ack: got quiet=%0b acks=%0d, want quiet=1 acks=0", ok, ack_vecs.size() - ab0);
      end
      xfer_len = 3;
      tb0 = trmt_bytes.size();
      ab0 = ack_vecs.size();
      model_order(4'b0010);
      post(4'b0010, {16'h0, 8'h3C, 8'h00});
      wait_quiet(100, ok);
      n_tests++;
      if (!ok || trmt_bytes.size() != tb0 + 1 || ack_vecs.size() != ab0 + 1) begin
         n_fail++;
         $display("[TB] FAIL rstmid_after_count: got quiet=%0b bytes=%0d acks=%0d, want 1 1 1",
                  ok, trmt_bytes.size() - tb0, ack_vecs.size() - ab0);
      end else if (trmt_bytes[tb0] !== 8'h3C || ack_vecs[ab0] !== 4'b0010) begin
         n_fail++;
         $display("[TB] FAIL rstmid_after: got byte=%h ack=%b, want byte=3c ack=0010", trmt_bytes[tb0], ack_vecs[ab0]);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 25; r++) begin
         logic [N-1:0]   mask;
         logic [N-1:0]   exp_ovf;
         logic [8*N-1:0] data;
         int             tb0, ab0, ov_src;
         bit             ok;
         mask = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) data[8*i +: 8] = 8'($urandom);
         drop_dly = $urandom_range(0, 3);
         xfer_len = $urandom_range(1, 6);
         exp_ovf  = '0;
         tb0 = trmt_bytes.size();
         ab0 = ack_vecs.size();
         model_order(mask);
         post(mask, data);
         if ($urandom_range(0, 1) == 1) begin
            ov_src      = exp_src[$urandom_range(0, exp_src.size() - 1)];
            req         = '0;
            req[ov_src] = 1'b1;
            req_data    = ~data;
            step();
            req = '0;
            exp_ovf[ov_src] = 1'b1;
         end
         wait_quiet(400, ok);
         n_tests++;
         if (!ok || ovf !== exp_ovf || trmt_bytes.size() != tb0 + exp_src.size() ||
             ack_vecs.size() != ab0 + exp_src.size()) begin
            n_fail++;
            $display("[TB] FAIL rand%0d_summary: got quiet=%0b ovf=%b bytes=%0d acks=%0d, want quiet=1 ovf=%b count=%0d",
                     r, ok, ovf, trmt_bytes.size() - tb0, ack_vecs.size() - ab0, exp_ovf, exp_src.size());
         end else begin
            for (int k = 0; k < exp_src.size(); k++) begin
               n_tests++;
               if (trmt_bytes[tb0+k] !== data[8*exp_src[k] +: 8] || ack_vecs[ab0+k] !== N'(1 << exp_src[k])) begin
                  n_fail++;
                  $display("[TB] FAIL rand%0d_order[%0d]: got byte=%h ack=%b, want byte=%h ack=%b", r, k,
                           trmt_bytes[tb0+k], ack_vecs[ab0+k], data[8*exp_src[k] +: 8], N'(1 << exp_src[k]));
               end
               if (k > 0) begin
                  n_tests++;
                  if (trmt_cyc[tb0+k] != ack_cyc[ab0+k-1] + 1) begin
                     n_fail++;
                     $display("[TB] FAIL rand%0d_b2b[%0d]: got trmt cycle=%0d, want %0d", r, k,
                              trmt_cyc[tb0+k], ack_cyc[ab0+k-1] + 1);
                  end
               end
            end
         end
         clr_ovf = 1'b1;
         step();
         clr_ovf = 1'b0;
      end
      n_tests++;
      if (glitch_cnt != 0) begin
         n_fail++;
         $display("[TB] FAIL resp_stable: got %0d resp changes while in flight, want 0", glitch_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_priority();
      test_overflow();
      test_post_on_completion();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
